// File: rtl/param_stream_loader.sv
// Run-time parameter loader: packs a valid/ready beat stream into a RAM and
// serves it through a ROM-compatible, two-stage registered read port.
module param_stream_loader #(
  parameter int PRECISION_0       = 16,
  parameter int TENSOR_SIZE_DIM_0 = 32,
  parameter int PARALLELISM_DIM_0 = 1,
  parameter int DEPTH             = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
  parameter int AWIDTH            = $clog2(DEPTH) + 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     load_start,
  input  logic [PRECISION_0-1:0]                   data_in [PARALLELISM_DIM_0],
  input  logic                                     data_in_valid,
  output logic                                     data_in_ready,
  output logic                                     busy,
  output logic                                     load_done,
  output logic [AWIDTH-1:0]                        beat_count,
  input  logic [AWIDTH-1:0]                        addr0,
  input  logic                                     ce0,
  output logic [PRECISION_0*PARALLELISM_DIM_0-1:0] q0
);

  localparam int WORD_W    = PRECISION_0 * PARALLELISM_DIM_0;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RAM_WORDS = 1 << IDX_W;

  localparam logic [AWIDTH-1:0] LAST_PTR = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] DEPTH_A  = AWIDTH'(DEPTH);
  localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] w_wr_ptr_next;
  logic              w_in_load;
  logic              w_handshake;
  logic [WORD_W-1:0] w_wr_word;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_rd_in_range;

  logic [WORD_W-1:0] r_ram [RAM_WORDS];
  logic [WORD_W-1:0] r_stage1;
  logic [WORD_W-1:0] r_q0;

  assign w_in_load   = (r_state == S_LOAD);
  assign w_handshake = w_in_load && data_in_valid;
  assign w_wr_idx    = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx    = addr0[IDX_W-1:0];
  assign w_rd_in_range = (addr0 < DEPTH_A);

  // Element j of the beat lands in word bits [PRECISION_0*j +: PRECISION_0].
  always_comb begin
    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    w_wr_word = '0;
    for (int j = 0; j < PARALLELISM_DIM_0; j++) begin
      w_wr_word[PRECISION_0*j +: PRECISION_0] = data_in[j];
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_wr_ptr_next = r_wr_ptr;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          w_state_next  = S_LOAD;
          w_wr_ptr_next = '0;
        end
      end
      S_LOAD: begin
        // load_start is deliberately ignored here, even alongside the final beat.
        if (w_handshake) begin
          if (r_wr_ptr == LAST_PTR) begin
            w_state_next  = S_DONE;
            w_wr_ptr_next = '0;
          end else begin
            w_wr_ptr_next = r_wr_ptr + PTR_ONE;
          end
        end
      end
      default: begin
        w_state_next  = S_IDLE;
        w_wr_ptr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_wr_ptr <= w_wr_ptr_next;
    end
  end

  // NOTE: the RAM array has no reset so it can map onto block memory; a reset leaves its contents intact.
  always_ff @(posedge clk) begin
    if (w_handshake) begin
      r_ram[w_wr_idx] <= w_wr_word;
    end
  end

  // Out-of-range addresses return zero; callers treat that value as undefined.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage1 <= '0;
      r_q0     <= '0;
    end else if (ce0) begin
      // NOTE: non-blocking assignment here means a read sees the pre-edge RAM word, giving read-first behaviour.
      r_stage1 <= w_rd_in_range ? r_ram[w_rd_idx] : '0;
      r_q0     <= r_stage1;
    end
  end

  assign q0            = r_q0;
  assign data_in_ready = w_in_load;
  assign busy          = w_in_load;
  assign load_done     = (r_state == S_DONE);

  always_comb begin
    beat_count = '0;
    if (r_state == S_LOAD) begin
      beat_count = r_wr_ptr;
    end else if (r_state == S_DONE) begin
      beat_count = DEPTH_A;
    end
  end

endmodule

// File: tb/tb_param_stream_loader.sv
// Directed-plus-random bench for param_stream_loader: a PAR=1 instance tracked
// by a behavioural model every cycle, and a PAR=4 instance for beat packing.
module tb_param_stream_loader;

  localparam int P   = 16;
  localparam int D   = 32;
  localparam int AW  = 6;
  localparam int D4  = 8;
  localparam int AW4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          valid = 1'b0;
  logic          ready, busy, done;
  logic [P-1:0]  data [1];
  logic [AW-1:0] bc;
  logic [AW-1:0] addr0 = '0;
  logic          ce0 = 1'b0;
  logic [P-1:0]  q0;

  logic           load4 = 1'b0;
  logic           valid4 = 1'b0;
  logic           ready4, busy4, done4;
  logic [P-1:0]   d4 [4];
  logic [AW4-1:0] bc4;
  logic [AW4-1:0] addr4 = '0;
  logic           ce4 = 1'b0;
  logic [4*P-1:0] q4;

  param_stream_loader #(.PRECISION_0(P), .TENSOR_SIZE_DIM_0(32), .PARALLELISM_DIM_0(1)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .data_in(data),
    .data_in_valid(valid), .data_in_ready(ready), .busy(busy), .load_done(done),
    .beat_count(bc), .addr0(addr0), .ce0(ce0), .q0(q0)
  );

  param_stream_loader #(.PRECISION_0(P), .TENSOR_SIZE_DIM_0(32), .PARALLELISM_DIM_0(4)) dut4 (
    .clk(clk), .rst(rst), .load_start(load4), .data_in(d4),
    .data_in_valid(valid4), .data_in_ready(ready4), .busy(busy4), .load_done(done4),
    .beat_count(bc4), .addr0(addr4), .ce0(ce4), .q0(q4)
  );

  // Behavioural model: phase 0=idle, 1=loading, 2=loaded; m_cnt = beats taken so far.
  int           m_phase = 0;
  int           m_cnt = 0;
  logic [P-1:0] m_ram [D];
  bit           m_wr [D];
  logic [P-1:0] m_s1 = '0;
  logic [P-1:0] m_q = '0;
  bit           m_s1_k = 1'b0;
  bit           m_q_k = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int ready_hi = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step();
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_s1    = '0;
      m_q     = '0;
      m_s1_k  = 1'b1;
      m_q_k   = 1'b1;
    end else begin
      if (ce0) begin
        m_q    = m_s1;
        m_q_k  = m_s1_k;
        m_s1_k = (int'(addr0) < D) && m_wr[addr0[4:0]];
        if (m_s1_k) m_s1 = m_ram[addr0[4:0]];
      end
      if (m_phase == 1) begin
        if (valid) begin
          m_ram[m_cnt] = data[0];
          m_wr[m_cnt]  = 1'b1;
          m_cnt++;
          if (m_cnt == D) m_phase = 2;
        end
      end else if (load_start) begin
        m_phase = 1;
        m_cnt   = 0;
      end
    end
  endfunction

  task automatic check_status();
    check("ready", ready, m_phase == 1);
    check("busy", busy, m_phase == 1);
    check("load_done", done, m_phase == 2);
    check("beat_count", bc, (m_phase == 0) ? 0 : m_cnt);
    if (m_q_k) check("q0_model", q0, m_q);
    if (ready === 1'b1) ready_hi++;
  endtask

  // Inputs change only at negedge; the model follows each posedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_status();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_beats(input logic [15:0] base, input bit rnd, input bit gaps,
                            input bit ls_last, input int upto);
    int guard;
    int g;
    guard = 0;
    while (m_phase == 1 && m_cnt < upto && guard < 500) begin
      if (gaps) begin
        g = $urandom_range(3, 0);
        for (int k = 0; k < g; k++) begin
          valid   = 1'b0;
          data[0] = 16'($urandom);
          tick();
        end
      end
      valid      = 1'b1;
      data[0]    = rnd ? 16'($urandom) : base + 16'(m_cnt);
      load_start = ls_last && (m_cnt == D - 1);
      tick();
      guard++;
    end
    valid      = 1'b0;
    load_start = 1'b0;
    data[0]    = 16'($urandom);
    check("beat_loop_bounded", guard < 500, 1'b1);
  endtask

  // Words below split hold new_base+a, the rest old_base+a.
  task automatic read_check(input logic [15:0] new_base, input logic [15:0] old_base, input int split);
    for (int a = 0; a <= D; a++) begin
      addr0 = (a < D) ? AW'(a) : AW'(D - 1);
      ce0   = 1'b1;
      tick();
      if (a >= 1) begin
        check("readback", q0, (a - 1 < split) ? new_base + 16'(a - 1) : old_base + 16'(a - 1));
      end
    end
    ce0 = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp4;
    data[0] = '0;
    for (int j = 0; j < 4; j++) d4[j] = '0;

    // Reset state.
    tick();
    tick();
    check("rst_q0", q0, 16'h0);
    check("rst_q4", q4, 64'h0);
    check("rst_ready4", ready4, 1'b0);
    rst = 1'b0;
    tick();

    // Continuous load of 0x1000+i.
    ready_hi = 0;
    start_load();
    send_beats(16'h1000, 1'b0, 1'b0, 1'b0, D);
    check("ready_cycles", ready_hi, 32);
    check("done_after_load", done, 1'b1);
    check("count_after_load", bc, 6'd32);
    tick();
    read_check(16'h1000, 16'h1000, D);

    // Random payload, then a gapped reload that must restore 0x1000+i exactly.
    start_load();
    send_beats(16'h0000, 1'b1, 1'b1, 1'b0, D);
    start_load();
    send_beats(16'h1000, 1'b0, 1'b1, 1'b0, D);
    read_check(16'h1000, 16'h1000, D);

    // Four-element beats on the wide instance.
    load4 = 1'b1;
    tick();
    load4 = 1'b0;
    check("p4_ready", ready4, 1'b1);
    check("p4_busy", busy4, 1'b1);
    for (int k = 0; k < D4; k++) begin
      valid4 = 1'b1;
      for (int j = 0; j < 4; j++) d4[j] = 16'(k * 4 + j);
      tick();
    end
    valid4 = 1'b0;
    check("p4_done", done4, 1'b1);
    check("p4_count", bc4, 4'd8);
    check("p4_ready_low", ready4, 1'b0);
    for (int a = 0; a <= D4; a++) begin
      addr4 = (a < D4) ? AW4'(a) : AW4'(D4 - 1);
      ce4   = 1'b1;
      tick();
      if (a >= 1) begin
        for (int j = 0; j < 4; j++) exp4[16*j +: 16] = 16'(4 * (a - 1) + j);
        check("p4_read", q4, exp4);
      end
    end
    addr4 = 4'd2;
    tick();
    tick();
    check("p4_addr2", q4, 64'h000B_000A_0009_0008);
    ce4 = 1'b0;

    // load_start together with the final beat is ignored.
    start_load();
    send_beats(16'h2000, 1'b0, 1'b0, 1'b1, D);
    check("ls_last_done", done, 1'b1);
    check("ls_last_count", bc, 6'd32);
    tick();
    check("ls_last_no_restart", ready, 1'b0);
    check("ls_last_still_done", done, 1'b1);
    read_check(16'h2000, 16'h2000, D);

    // Reset during a reload after 10 beats.
    start_load();
    send_beats(16'h1000, 1'b0, 1'b0, 1'b0, D);
    start_load();
    send_beats(16'h2000, 1'b0, 1'b0, 1'b0, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_count", bc, 6'd0);
    read_check(16'h2000, 16'h1000, 10);

    // ce0 low freezes both read stages.
    addr0 = 6'd7;
    ce0   = 1'b1;
    tick();
    addr0 = 6'd8;
    tick();
    check("pre_freeze", q0, 16'h2007);
    ce0   = 1'b0;
    addr0 = 6'd20;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("frozen", q0, 16'h2007);
    end
    ce0 = 1'b1;
    tick();
    check("unfreeze", q0, 16'h2008);
    ce0 = 1'b0;

    // Same-cycle write and read of word 5 is read-first.
    start_load();
    send_beats(16'h3000, 1'b0, 1'b0, 1'b0, 5);
    valid   = 1'b1;
    data[0] = 16'h3005;
    addr0   = 6'd5;
    ce0     = 1'b1;
    tick();
    valid   = 1'b0;
    data[0] = 16'hDEAD;
    tick();
    check("rdw_old", q0, 16'h2005);
    tick();
    check("rdw_new", q0, 16'h3005);
    ce0 = 1'b0;
    send_beats(16'h3000, 1'b0, 1'b0, 1'b0, D);
    read_check(16'h3000, 16'h3000, D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/param_stream_loader.md
Name: param_stream_loader

Overview:
- Writer-side counterpart to the parameter ROM sources.
- Accepts a valid/ready stream of parameter beats (PARALLELISM_DIM_0 elements per beat) and packs them into an internal RAM of DEPTH words.
- Once a full tensor is loaded, serves random reads through an addr0/ce0/q0 port with the same 2-cycle registered latency as the parameter ROMs, so it can stand in for a ROM when weights or biases are loaded at run time.

Parameters:
- PRECISION_0, 16: element width in bits.
- TENSOR_SIZE_DIM_0, 32: elements per tensor.
- PARALLELISM_DIM_0, 1: elements per beat and per RAM word.
- DEPTH, TENSOR_SIZE_DIM_0/PARALLELISM_DIM_0: beats per load, and RAM words.
- AWIDTH, $clog2(DEPTH)+1: address and pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse; begins a (re)load.
- data_in  in  PRECISION_0 x PARALLELISM_DIM_0 (unpacked array)  beat payload; element j maps to word bits [PRECISION_0*j +: PRECISION_0].
- data_in_valid  in  1  beat valid.
- data_in_ready  out  1  beat accepted when valid && ready.
- busy  out  1  high in the LOAD state.
- load_done  out  1  high in the DONE state.
- beat_count  out  AWIDTH  beats accepted in the current load.
- addr0  in  AWIDTH  read address.
- ce0  in  1  read pipeline enable.
- q0  out  PRECISION_0*PARALLELISM_DIM_0  read data.

Behaviour:
- Reset: state=IDLE; wr_ptr=0; beat_count=0; data_in_ready=0; busy=0; load_done=0; both q0 pipeline registers=0. RAM contents are not cleared.
- States:
  - IDLE: ready=0. load_start -> LOAD, wr_ptr=0.
  - LOAD: ready=1, busy=1. Each handshake writes RAM[wr_ptr] and increments wr_ptr. The handshake at wr_ptr==DEPTH-1 -> DONE, with wr_ptr wrapping to 0.
  - DONE: ready=0, load_done=1. load_start -> LOAD, wr_ptr=0, load_done drops the next cycle.
- Outputs are Moore, decoded from state: data_in_ready rises the cycle after load_start is sampled and falls the cycle after the final beat.
- beat_count:
  - equals wr_ptr in LOAD;
  - holds DEPTH in DONE;
  - is 0 in IDLE and on entry to LOAD.
- load_start in LOAD is ignored, including in the same cycle as the final handshake: the final beat is accepted and the state goes to DONE.
- valid low in LOAD: no write, pointer holds. Stalls of any length are legal.
- The payload is ignored whenever no handshake occurs.
- Read port:
  - When ce0=1, stage1 <= RAM[addr0] and q0 <= stage1, so data appears 2 cycles after addr0 is presented.
  - When ce0=0, both stages hold.
  - addr0 >= DEPTH returns an undefined value; the bench must not check it.
  - Reads are legal in every state.
- Read-during-write to the same address is read-first: stage1 captures the old word, and the new word is visible to reads issued on the next cycle.
- Reset mid-LOAD returns to IDLE. Words already written stay in the RAM but the load is not complete (load_done=0).
- DEPTH==1: the first handshake goes directly to DONE.

Test Plan:
- Reset, then load_start, then 32 beats (PAR=1) carrying 0x1000+i with continuous valid -> data_in_ready high for exactly 32 cycles, load_done=1 from the cycle after beat 31, beat_count=32. Then reading addr 0..31 with ce0=1 returns 0x1000+addr 2 cycles later.
- Same load with valid toggling 1-0 and random 0-3 cycle gaps -> identical RAM contents, with no write on any valid=0 cycle.
- PAR=4, TENSOR=32: 8 beats, element j of beat k = 16'h(k*4+j) -> q0 at addr 2 = {16'h000B, 16'h000A, 16'h0009, 16'h0008}.
- load_start asserted together with beat 31 -> beat accepted, state DONE, no restart. A second load with payload 0x2000+i then overwrites all words and read-back returns 0x2000+i.
- Reset asserted after beat 10 of a reload -> next cycle ready=0, busy=0, load_done=0. Words 0-9 read back 0x2000+i and words 10-31 still read 0x1000+i.
- ce0 held 0 for 3 cycles mid-read -> q0 frozen. Same-cycle write and read of address 5 returns the old value, and a read issued one cycle later returns the new value.
